// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution loop controller
package conv_pkg;
  localparam int STRIDE_W = 4;
  localparam int LP_CNT_W = 10;
  localparam int L_FX = 0;
  localparam int L_FY = 1;
  localparam int L_IC = 2;
  localparam int L_OX = 3;
  localparam int L_OY = 4;
  localparam int L_OC = 5;
  typedef struct packed {
    logic [LP_CNT_W-1:0] oc;
    logic [LP_CNT_W-1:0] oy;
    logic [LP_CNT_W-1:0] ox;
    logic [LP_CNT_W-1:0] ic;
    logic [LP_CNT_W-1:0] fy;
    logic [LP_CNT_W-1:0] fx;
    logic [STRIDE_W-1:0] stride;
  } layer_params_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/conv_loop_cnt.sv
// conv_loop_cnt: six-level carry chain (fx innermost) with incremental ifmap coordinates
module conv_loop_cnt
  import conv_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int IDX_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     adv,
  input  logic [5:0][CNT_W-1:0]    lim,
  input  logic [STRIDE_W-1:0]      stride,
  output logic [5:0][CNT_W-1:0]    cnt,
  output logic [IDX_W-1:0]         iy,
  output logic [IDX_W-1:0]         ix,
  output logic                     pix_first,
  output logic                     pix_last,
  output logic                     layer_last
);
  logic [5:0] at_max;
  logic [6:0] carry;
  logic [IDX_W-1:0] oy_base, ox_base;
  assign carry[0] = adv;
  for (genvar g = 0; g < 6; g++) begin : g_lvl
    assign at_max[g] = cnt[g] == lim[g] - CNT_W'(1);
    assign carry[g+1] = carry[g] & at_max[g];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt[g] <= '0;
      else if (clr) cnt[g] <= '0;
      else if (carry[g]) cnt[g] <= at_max[g] ? '0 : cnt[g] + CNT_W'(1);
  end
  // bases track oy*stride and ox*stride by accumulation instead of multiplying
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      oy_base <= '0;
      ox_base <= '0;
    end else if (clr) begin
      oy_base <= '0;
      ox_base <= '0;
    end else begin
      if (carry[L_OX]) ox_base <= at_max[L_OX] ? '0 : ox_base + IDX_W'(stride);
      if (carry[L_OY]) oy_base <= at_max[L_OY] ? '0 : oy_base + IDX_W'(stride);
    end
  assign iy = oy_base + IDX_W'(cnt[L_FY]);
  assign ix = ox_base + IDX_W'(cnt[L_FX]);
  assign pix_first = cnt[L_IC] == '0 && cnt[L_FY] == '0 && cnt[L_FX] == '0;
  assign pix_last = &at_max[L_IC:L_FX];
  assign layer_last = &at_max;
endmodule

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: walks oc/oy/ox/ic/fy/fx loops of a conv layer, one MAC step per handshake
module conv_loop_ctrl
  import conv_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int IDX_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  layer_params_t      layer_params_dat,
  input  logic               layer_params_vld,
  output logic               layer_params_rdy,
  output logic               step_vld,
  input  logic               step_rdy,
  output logic [CNT_W-1:0]   step_oc,
  output logic [CNT_W-1:0]   step_oy,
  output logic [CNT_W-1:0]   step_ox,
  output logic [CNT_W-1:0]   step_ic,
  output logic [CNT_W-1:0]   step_fy,
  output logic [CNT_W-1:0]   step_fx,
  output logic [IDX_W-1:0]   step_iy,
  output logic [IDX_W-1:0]   step_ix,
  output logic               acc_first,
  output logic               acc_last,
  output logic               busy,
  output logic               done
);
  state_t state, state_nxt;
  logic [5:0][CNT_W-1:0] lim, cnt;
  logic [STRIDE_W-1:0] stride;
  logic hs_par, hs_step, zero_dim, pix_first, pix_last, layer_last;
  assign hs_par = layer_params_vld & layer_params_rdy;
  assign hs_step = step_vld & step_rdy;
  assign zero_dim = layer_params_dat.oc == '0 || layer_params_dat.oy == '0 ||
                    layer_params_dat.ox == '0 || layer_params_dat.ic == '0 ||
                    layer_params_dat.fy == '0 || layer_params_dat.fx == '0;
  always_comb begin
    state_nxt = state == IDLE ? (hs_par ? (zero_dim ? DONE : RUN) : IDLE) :
                state == RUN  ? (hs_step && layer_last ? DONE : RUN) : IDLE;
    step_vld = state == RUN;
    busy = state != IDLE;
    done = state == DONE;
  end
  // rdy is its own flop so it stays low in reset and rises one edge after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      layer_params_rdy <= 1'b0;
    end else begin
      state <= state_nxt;
      layer_params_rdy <= state_nxt == IDLE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lim <= '0;
      stride <= '0;
    end else if (hs_par) begin
      lim <= {CNT_W'(layer_params_dat.oc), CNT_W'(layer_params_dat.oy),
              CNT_W'(layer_params_dat.ox), CNT_W'(layer_params_dat.ic),
              CNT_W'(layer_params_dat.fy), CNT_W'(layer_params_dat.fx)};
      stride <= layer_params_dat.stride == '0 ? STRIDE_W'(1) : layer_params_dat.stride;
    end
  conv_loop_cnt #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(hs_par),
    .adv(hs_step),
    .lim(lim),
    .stride(stride),
    .cnt(cnt),
    .iy(step_iy),
    .ix(step_ix),
    .pix_first(pix_first),
    .pix_last(pix_last),
    .layer_last(layer_last)
  );
  assign step_oc = cnt[L_OC];
  assign step_oy = cnt[L_OY];
  assign step_ox = cnt[L_OX];
  assign step_ic = cnt[L_IC];
  assign step_fy = cnt[L_FY];
  assign step_fx = cnt[L_FX];
  assign acc_first = step_vld & pix_first;
  assign acc_last = step_vld & pix_last;
endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: random-backpressure bench against a nested-loop reference model
module tb_conv_loop_ctrl;
  import conv_pkg::*;
  localparam int CNT_W = 10;
  localparam int IDX_W = 16;
  logic clk = 1'b0;
  logic rst_n;
  layer_params_t layer_params_dat;
  logic layer_params_vld, layer_params_rdy, step_vld, step_rdy;
  logic [CNT_W-1:0] step_oc, step_oy, step_ox, step_ic, step_fy, step_fx;
  logic [IDX_W-1:0] step_iy, step_ix;
  logic acc_first, acc_last, busy, done;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  conv_loop_ctrl #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .layer_params_dat(layer_params_dat), .layer_params_vld(layer_params_vld),
    .layer_params_rdy(layer_params_rdy),
    .step_vld(step_vld), .step_rdy(step_rdy),
    .step_oc(step_oc), .step_oy(step_oy), .step_ox(step_ox),
    .step_ic(step_ic), .step_fy(step_fy), .step_fx(step_fx),
    .step_iy(step_iy), .step_ix(step_ix),
    .acc_first(acc_first), .acc_last(acc_last), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pack(input int oc, oy, ox, ic, fy, fx, iy, ix,
                                        input logic af, al);
    return 128'({CNT_W'(oc), CNT_W'(oy), CNT_W'(ox), CNT_W'(ic), CNT_W'(fy), CNT_W'(fx),
                 IDX_W'(iy), IDX_W'(ix), af, al});
  endfunction
  function automatic logic [127:0] obs();
    return 128'({step_oc, step_oy, step_ox, step_ic, step_fy, step_fx,
                 step_iy, step_ix, acc_first, acc_last});
  endfunction
  function automatic layer_params_t mk(input int oc, oy, ox, ic, fy, fx, st);
    layer_params_t p;
    p.oc = LP_CNT_W'(oc); p.oy = LP_CNT_W'(oy); p.ox = LP_CNT_W'(ox);
    p.ic = LP_CNT_W'(ic); p.fy = LP_CNT_W'(fy); p.fx = LP_CNT_W'(fx);
    p.stride = STRIDE_W'(st);
    return p;
  endfunction
  // expected step list straight from the loop-nest definition, iy/ix by multiplication
  task automatic build(input layer_params_t p, output logic [127:0] q[$]);
    int s;
    s = p.stride == 0 ? 1 : int'(p.stride);
    q = {};
    for (int oc = 0; oc < int'(p.oc); oc++)
      for (int oy = 0; oy < int'(p.oy); oy++)
        for (int ox = 0; ox < int'(p.ox); ox++)
          for (int ic = 0; ic < int'(p.ic); ic++)
            for (int fy = 0; fy < int'(p.fy); fy++)
              for (int fx = 0; fx < int'(p.fx); fx++)
                q.push_back(pack(oc, oy, ox, ic, fy, fx, oy * s + fy, ox * s + fx,
                                 ic == 0 && fy == 0 && fx == 0,
                                 ic == int'(p.ic) - 1 && fy == int'(p.fy) - 1 &&
                                 fx == int'(p.fx) - 1));
  endtask
  task automatic send(input layer_params_t p);
    int cyc = 0;
    while (!layer_params_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("par_rdy_wait", 128'(layer_params_rdy), 128'(1));
    layer_params_dat = p;
    layer_params_vld = 1'b1;
    step_rdy = 1'b0;
    @(negedge clk);
    layer_params_vld = 1'b0;
  endtask
  task automatic run_layer(input layer_params_t p, input int rdy_pct);
    logic [127:0] q[$];
    int total, n, cyc, limit;
    build(p, q);
    total = q.size();
    n = 0;
    cyc = 0;
    limit = total * 20 + 50;
    send(p);
    while (q.size() > 0 && cyc < limit) begin
      chk("step_vld", 128'(step_vld), 128'(1));
      chk("step", obs(), q[0]);
      chk("par_rdy_run", 128'(layer_params_rdy), 128'(0));
      chk("done_early", 128'(done), 128'(0));
      step_rdy = $urandom_range(99) < rdy_pct;
      if (step_rdy) begin
        void'(q.pop_front());
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    step_rdy = 1'b0;
    chk("handshakes", 128'(n), 128'(total));
    if (rdy_pct >= 100) chk("one_per_cycle", 128'(cyc), 128'(total));
    chk("vld_after", 128'(step_vld), 128'(0));
    chk("done_pulse", 128'(done), 128'(1));
    @(negedge clk);
    chk("idle", 128'({done, busy, layer_params_rdy}), 128'(3'b001));
  endtask
  initial begin
    logic [127:0] q[$];
    rst_n = 1'b0;
    layer_params_vld = 1'b0;
    layer_params_dat = '0;
    step_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", obs(), 128'(0));
    chk("reset_ctl", 128'({layer_params_rdy, step_vld, busy, done}), 128'(0));
    rst_n = 1'b1;
    #1 chk("rdy_pre_edge", 128'(layer_params_rdy), 128'(0));
    @(negedge clk);
    chk("rdy_post_rst", 128'({layer_params_rdy, busy}), 128'(2'b10));
    run_layer(mk(1, 1, 2, 1, 1, 2, 1), 100);
    run_layer(mk(1, 1, 3, 1, 1, 3, 2), 100);
    run_layer(mk(1, 1, 2, 1, 1, 2, 1), 40);
    run_layer(mk(2, 2, 2, 0, 2, 2, 1), 100);
    run_layer(mk(1, 2, 2, 1, 2, 2, 0), 70);
    for (int t = 0; t < 12; t++)
      run_layer(mk($urandom_range(1, 2), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(1, 2), $urandom_range(1, 3), $urandom_range(1, 3),
                   $urandom_range(0, 3)), $urandom_range(30, 100));
    // abandon an 8-step layer after three steps
    build(mk(1, 1, 8, 1, 1, 1, 1), q);
    send(mk(1, 1, 8, 1, 1, 1, 1));
    step_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_abort", obs(), q[3]);
    rst_n = 1'b0;
    #1 chk("abort", 128'({step_vld, busy, done, step_ox}), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 128'(done), 128'(0));
    end
    step_rdy = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_layer(mk(1, 1, 8, 1, 1, 1, 1), 60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
